irrigation_cycle_scheduler: RTL and testbench

//  Sequences the shared water line between sprinkler and drip requesters. Runs timed watering

---
 rtl/irrigation_cycle_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_irrigation_cycle_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_cycle_scheduler.sv
// Water-line scheduler: round-robin sprinkler/drip cycles timed by a 1 Hz tick, with rest gap and
// tank-level/sensor-error interlocks. Optional manual sprinkler start under IRRIG_MANUAL_EN.
module irrigation_cycle_scheduler #(
  parameter int unsigned TIMER_W        = 12,
  parameter int unsigned SPRINKLER_TIME = 600,
  parameter int unsigned DRIP_TIME      = 1200,
  parameter int unsigned REST_TIME      = 300
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               sprinkler_req_i,
  input  logic               drip_req_i,
  input  logic [1:0]         level_code_i,
  input  logic               error_i,
`ifdef IRRIG_MANUAL_EN
  input  logic               manual_start_i,
`endif
  output logic               sprinkler_valve_o,
  output logic               drip_valve_o,
  output logic               busy_o,
  output logic               fault_o,
  output logic               cycle_done_o,
  output logic               abort_o,
  output logic [TIMER_W-1:0] remaining_o
);

  localparam logic [TIMER_W-1:0] L_SPR_LOAD  = TIMER_W'(SPRINKLER_TIME);
  localparam logic [TIMER_W-1:0] L_DRIP_LOAD = TIMER_W'(DRIP_TIME);
  localparam logic [TIMER_W-1:0] L_REST_LOAD = TIMER_W'(REST_TIME);
  localparam logic [TIMER_W-1:0] L_ONE       = TIMER_W'(1);
  localparam logic               L_LAST_S    = 1'b0;
  localparam logic               L_LAST_D    = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WATER_S = 3'd1,
    S_WATER_D = 3'd2,
    S_REST    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t             r_state;
  logic [TIMER_W-1:0] r_cnt;
  logic               r_last;
  logic               r_valve_s;
  logic               r_valve_d;
  logic               r_busy;
  logic               r_fault;
  logic               r_done;
  logic               r_abort;

  state_t             w_state_nxt;
  logic [TIMER_W-1:0] w_cnt_nxt;
  logic               w_last_nxt;
  logic               w_done;
  logic               w_abort;
  logic               w_elig_s;
  logic               w_elig_d;
  logic               w_manual;

  assign w_elig_s = sprinkler_req_i && (level_code_i >= 2'b10);
  assign w_elig_d = drip_req_i && (level_code_i >= 2'b01);

`ifdef IRRIG_MANUAL_EN
  // Manual start only honoured when the sprinkler level interlock holds
  assign w_manual = manual_start_i && (level_code_i >= 2'b10);
`else
  assign w_manual = 1'b0;
`endif

  // Next-state and counter logic; sensor error overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    if (error_i) begin
      w_state_nxt = S_FAULT;
      w_cnt_nxt   = '0;
      w_abort     = (r_state == S_WATER_S) || (r_state == S_WATER_D);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_manual || (w_elig_s && (!w_elig_d || (r_last == L_LAST_D)))) begin
            w_state_nxt = S_WATER_S;
            w_cnt_nxt   = L_SPR_LOAD;
            w_last_nxt  = L_LAST_S;
          end else if (w_elig_d) begin
            w_state_nxt = S_WATER_D;
            w_cnt_nxt   = L_DRIP_LOAD;
            w_last_nxt  = L_LAST_D;
          end
        end
        S_WATER_S: begin
          if (tick_i && (r_cnt == L_ONE)) begin
            w_state_nxt = S_REST;
            w_cnt_nxt   = L_REST_LOAD;
            w_done      = 1'b1;
          end else if (!w_elig_s) begin
            w_state_nxt = S_REST;
            w_cnt_nxt   = L_REST_LOAD;
            w_abort     = 1'b1;
          end else if (tick_i) begin
            w_cnt_nxt   = r_cnt - L_ONE;
          end
        end
        S_WATER_D: begin
          if (tick_i && (r_cnt == L_ONE)) begin
            w_state_nxt = S_REST;
            w_cnt_nxt   = L_REST_LOAD;
            w_done      = 1'b1;
          end else if (!w_elig_d) begin
            w_state_nxt = S_REST;
            w_cnt_nxt   = L_REST_LOAD;
            w_abort     = 1'b1;
          end else if (tick_i) begin
            w_cnt_nxt   = r_cnt - L_ONE;
          end
        end
        S_REST: begin
          if (w_manual) begin
            w_state_nxt = S_WATER_S;
            w_cnt_nxt   = L_SPR_LOAD;
            w_last_nxt  = L_LAST_S;
          end else if (tick_i) begin
            if (r_cnt == L_ONE) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt - L_ONE;
            end
          end
        end
        S_FAULT: begin
          w_cnt_nxt = '0;
          if (tick_i) begin
            w_state_nxt = S_REST;
            w_cnt_nxt   = L_REST_LOAD;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register; outputs are registered from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= L_LAST_D;
      r_valve_s <= 1'b0;
      r_valve_d <= 1'b0;
      r_busy    <= 1'b0;
      r_fault   <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_valve_s <= (w_state_nxt == S_WATER_S);
      r_valve_d <= (w_state_nxt == S_WATER_D);
      r_busy    <= (w_state_nxt == S_WATER_S) || (w_state_nxt == S_WATER_D) ||
                   (w_state_nxt == S_REST);
      r_fault   <= (w_state_nxt == S_FAULT);
      r_done    <= w_done;
      r_abort   <= w_abort;
    end
  end

  assign sprinkler_valve_o = r_valve_s;
  assign drip_valve_o      = r_valve_d;
  assign busy_o            = r_busy;
  assign fault_o           = r_fault;
  assign cycle_done_o      = r_done;
  assign abort_o           = r_abort;
  assign remaining_o       = r_cnt;

endmodule

// File: tb/tb_irrigation_cycle_scheduler.sv
// Scoreboard bench for irrigation_cycle_scheduler: stimulus queues each expected output change,
// a negedge monitor pops and compares whenever the output vector changes.
module tb_irrigation_cycle_scheduler;
  localparam int unsigned TW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_i = 1'b0;
  logic          spr = 1'b0;
  logic          drip = 1'b0;
  logic [1:0]    lvl = 2'b00;
  logic          err = 1'b0;
`ifdef IRRIG_MANUAL_EN
  logic          man = 1'b0;
`endif
  logic          vs, vd, busy, fault, done, abort;
  logic [TW-1:0] rem;

  irrigation_cycle_scheduler #(
    .TIMER_W(TW), .SPRINKLER_TIME(4), .DRIP_TIME(6), .REST_TIME(3)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tick_i            (tick_i),
    .sprinkler_req_i   (spr),
    .drip_req_i        (drip),
    .level_code_i      (lvl),
    .error_i           (err),
`ifdef IRRIG_MANUAL_EN
    .manual_start_i    (man),
`endif
    .sprinkler_valve_o (vs),
    .drip_valve_o      (vd),
    .busy_o            (busy),
    .fault_o           (fault),
    .cycle_done_o      (done),
    .abort_o           (abort),
    .remaining_o       (rem)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] exp_q[$];
  string       nm_q[$];
  logic [17:0] prev = '0;
  bit          mon_en = 1'b0;
  logic [17:0] cur;

  assign cur = {vs, vd, busy, fault, done, abort, rem};

  // {sprinkler_valve, drip_valve, busy, fault, cycle_done, abort, remaining}
  task automatic push_exp(input string n, input logic a, input logic b, input logic c,
                          input logic d, input logic e, input logic f, input int r);
    exp_q.push_back({a, b, c, d, e, f, TW'(r)});
    nm_q.push_back(n);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_once();
    tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
    step(1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [17:0] e;
      string       n;
      checks++;
      if (vs && vd) begin
        errors++;
        $display("FAIL valve_exclusive got vs=%0b vd=%0b", vs, vd);
      end
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got %h (no expectation queued)", cur);
        end else begin
          e = exp_q.pop_front();
          n = nm_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL %s got %b_%0d expected %b_%0d", n, cur[17:12], cur[11:0],
                     e[17:12], e[11:0]);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cur !== 18'd0) begin
      errors++;
      $display("FAIL reset_state got %h expected 0", cur);
    end
    prev   = '0;
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // Single sprinkler cycle, request dropped on the completing tick
    lvl = 2'b11; spr = 1'b1;
    push_exp("t1_grant", 1, 0, 1, 0, 0, 0, 4); step(1);
    push_exp("t1_rem3", 1, 0, 1, 0, 0, 0, 3); tick_once();
    push_exp("t1_rem2", 1, 0, 1, 0, 0, 0, 2); tick_once();
    push_exp("t1_rem1", 1, 0, 1, 0, 0, 0, 1); tick_once();
    spr = 1'b0;
    push_exp("t1_done", 0, 0, 1, 0, 1, 0, 3);
    push_exp("t1_done_clr", 0, 0, 1, 0, 0, 0, 3); tick_once();
    push_exp("t1_rest2", 0, 0, 1, 0, 0, 0, 2); tick_once();
    push_exp("t1_rest1", 0, 0, 1, 0, 0, 0, 1); tick_once();
    push_exp("t1_idle", 0, 0, 0, 0, 0, 0, 0); tick_once();

    // Both requesting: drip follows the sprinkler, then sprinkler again
    spr = 1'b1; drip = 1'b1;
    push_exp("t2_grant_d", 0, 1, 1, 0, 0, 0, 6); step(1);
    for (int r = 5; r >= 1; r--) begin
      push_exp("t2_drip_rem", 0, 1, 1, 0, 0, 0, r); tick_once();
    end
    push_exp("t2_done", 0, 0, 1, 0, 1, 0, 3);
    push_exp("t2_done_clr", 0, 0, 1, 0, 0, 0, 3); tick_once();
    push_exp("t2_rest2", 0, 0, 1, 0, 0, 0, 2); tick_once();
    push_exp("t2_rest1", 0, 0, 1, 0, 0, 0, 1); tick_once();
    push_exp("t2_idle", 0, 0, 0, 0, 0, 0, 0);
    push_exp("t2_grant_s", 1, 0, 1, 0, 0, 0, 4); tick_once();

    // Level falls to low at cnt=2: sprinkler aborts, drip served after rest
    push_exp("t3_rem3", 1, 0, 1, 0, 0, 0, 3); tick_once();
    push_exp("t3_rem2", 1, 0, 1, 0, 0, 0, 2); tick_once();
    lvl = 2'b01;
    push_exp("t3_abort", 0, 0, 1, 0, 0, 1, 3);
    push_exp("t3_abort_clr", 0, 0, 1, 0, 0, 0, 3); step(2);
    push_exp("t3_rest2", 0, 0, 1, 0, 0, 0, 2); tick_once();
    push_exp("t3_rest1", 0, 0, 1, 0, 0, 0, 1); tick_once();
    push_exp("t3_idle", 0, 0, 0, 0, 0, 0, 0);
    push_exp("t3_grant_d", 0, 1, 1, 0, 0, 0, 6); tick_once();

    // Sensor error during drip, then recovery through rest
    push_exp("t4_rem5", 0, 1, 1, 0, 0, 0, 5); tick_once();
    err = 1'b1;
    push_exp("t4_fault", 0, 0, 0, 1, 0, 1, 0);
    push_exp("t4_fault_clr", 0, 0, 0, 1, 0, 0, 0); step(1);
    err = 1'b0; step(1);
    push_exp("t4_rest3", 0, 0, 1, 0, 0, 0, 3); tick_once();
    spr = 1'b0; drip = 1'b0;
    push_exp("t4_rest2", 0, 0, 1, 0, 0, 0, 2); tick_once();
    push_exp("t4_rest1", 0, 0, 1, 0, 0, 0, 1); tick_once();
    push_exp("t4_idle", 0, 0, 0, 0, 0, 0, 0); tick_once();

    // Error from IDLE: fault without abort
    err = 1'b1;
    push_exp("t4b_fault_idle", 0, 0, 0, 1, 0, 0, 0); step(1);
    err = 1'b0; step(1);
    push_exp("t4b_rest3", 0, 0, 1, 0, 0, 0, 3); tick_once();
    push_exp("t4b_rest2", 0, 0, 1, 0, 0, 0, 2); tick_once();
    push_exp("t4b_rest1", 0, 0, 1, 0, 0, 0, 1); tick_once();
    push_exp("t4b_idle", 0, 0, 0, 0, 0, 0, 0); tick_once();

    // Reset mid-sprinkler, then dual request restarts with sprinkler
    lvl = 2'b11; spr = 1'b1;
    push_exp("t5_grant", 1, 0, 1, 0, 0, 0, 4); step(1);
    push_exp("t5_rem3", 1, 0, 1, 0, 0, 0, 3); tick_once();
    drip = 1'b1;
    push_exp("t5_reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (vs || vd || busy) begin
      errors++;
      $display("FAIL t5_async_reset got vs=%0b vd=%0b busy=%0b expected 0", vs, vd, busy);
    end
    step(2);
    rst_n = 1'b1;
    push_exp("t5_first_grant_s", 1, 0, 1, 0, 0, 0, 4); step(1);
    spr = 1'b0; drip = 1'b0;
    push_exp("t5_abort", 0, 0, 1, 0, 0, 1, 3);
    push_exp("t5_abort_clr", 0, 0, 1, 0, 0, 0, 3); step(2);
    push_exp("t5_rest2", 0, 0, 1, 0, 0, 0, 2); tick_once();
    push_exp("t5_rest1", 0, 0, 1, 0, 0, 0, 1); tick_once();
    push_exp("t5_idle", 0, 0, 0, 0, 0, 0, 0); tick_once();

`ifdef IRRIG_MANUAL_EN
    // Manual start in REST: dropped at low level, honoured at middle level
    err = 1'b1;
    push_exp("t6_fault", 0, 0, 0, 1, 0, 0, 0); step(1);
    err = 1'b0; step(1);
    push_exp("t6_rest3", 0, 0, 1, 0, 0, 0, 3); tick_once();
    push_exp("t6_rest2", 0, 0, 1, 0, 0, 0, 2); tick_once();
    lvl = 2'b01; man = 1'b1; step(1);
    man = 1'b0; step(2);
    lvl = 2'b10; man = 1'b1;
    push_exp("t6_manual_grant", 1, 0, 1, 0, 0, 0, 4);
    push_exp("t6_manual_abort", 0, 0, 1, 0, 0, 1, 3);
    push_exp("t6_manual_abort_clr", 0, 0, 1, 0, 0, 0, 3); step(1);
    man = 1'b0; step(2);
    push_exp("t6_rest2b", 0, 0, 1, 0, 0, 0, 2); tick_once();
    push_exp("t6_rest1b", 0, 0, 1, 0, 0, 0, 1); tick_once();
    push_exp("t6_idle", 0, 0, 0, 0, 0, 0, 0); tick_once();
`endif

    step(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
